// File: rtl/mux_n_to_1_rr.sv
// Registered N-way selector with valid/ready on every port.
// Fixed-select or round-robin arbitration into a 1-entry output register.
module mux_n_to_1_rr #(
  parameter int NUM_IN = 8,
  parameter int DATA_W = 64,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     en,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(NUM_IN - 1);

  logic              load;
  logic              any;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  nxt_ptr;
  logic [DATA_W-1:0] gdata;

  // Output register can take a beat when empty or draining this cycle.
  assign load = ~out_valid | out_ready;

  // Grant one channel: fixed index or first valid at/after ptr (wrapping).
  always_comb begin
    int j;
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    j     = 0;
    if (en && load) begin
      if (!mode) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (sel == SEL_W'(i) && in_valid[i]) begin
            grant[i] = 1'b1;
            any      = 1'b1;
            idx      = SEL_W'(i);
          end
        end
      end else begin
        for (int k = 0; k < NUM_IN; k++) begin
          j = int'(ptr) + k;
          if (j >= NUM_IN) j = j - NUM_IN;
          if (!any && in_valid[j]) begin
            grant[j] = 1'b1;
            any      = 1'b1;
            idx      = SEL_W'(j);
          end
        end
      end
    end
  end

  // Data of the granted channel; grant is one-hot or empty.
  always_comb begin
    gdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) gdata = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin restarts just past the winner.
  assign nxt_ptr = (idx == LAST) ? '0 : idx + 1'b1;

  // No handshake accepted while reset is held.
  assign in_ready = grant & {NUM_IN{rst_n}};

  // Output register, pointer and saturating transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
      ptr       <= '0;
    end else if (any) begin
      out_data  <= gdata;
      out_src   <= idx;
      out_valid <= 1'b1;
      if (xfer_cnt != CNT_MAX) xfer_cnt <= xfer_cnt + 1'b1;
      if (mode) ptr <= nxt_ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Directed bench for mux_n_to_1_rr: vector table plus reset,
// stall and counter-saturation sequences.
module tb_mux_n_to_1_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [511:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [3:0]  sel;
  logic        en;
  logic [63:0] out_data;
  logic [3:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic [23:0] s_data;
  logic [2:0]  s_valid;
  logic [2:0]  s_ready;
  logic        s_mode;
  logic [1:0]  s_sel;
  logic        s_en;
  logic [7:0]  s_odata;
  logic [1:0]  s_src;
  logic        s_ov;
  logic        s_ordy;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_to_1_rr #(
    .NUM_IN(8), .DATA_W(64), .SEL_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .en(en),
    .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt)
  );

  mux_n_to_1_rr #(
    .NUM_IN(3), .DATA_W(8), .SEL_W(2), .CNT_W(3)
  ) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .mode(s_mode), .sel(s_sel), .en(s_en),
    .out_data(s_odata), .out_src(s_src),
    .out_valid(s_ov), .out_ready(s_ordy),
    .xfer_cnt(s_cnt)
  );

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic        en;
    logic [7:0]  iv;
    logic        ordy;
    logic [7:0]  rdy;
    logic        ov;
    logic [3:0]  src;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(logic [63:0] base);
    for (int k = 0; k < 8; k++) in_data[k*64 +: 64] = base + 64'(k);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // mode sel en iv ordy | rdy ov src cnt
    tbl.push_back('{0, 5, 1, 8'hFF, 1, 8'h20, 1, 5, 1});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h01, 1, 0, 2});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h02, 1, 1, 3});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h04, 1, 2, 4});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h08, 1, 3, 5});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h10, 1, 4, 6});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h20, 1, 5, 7});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h40, 1, 6, 8});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h80, 1, 7, 9});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h01, 1, 0, 10});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h02, 1, 1, 11});
    tbl.push_back('{1, 0, 1, 8'h44, 1, 8'h04, 1, 2, 12});
    tbl.push_back('{1, 0, 1, 8'h44, 1, 8'h40, 1, 6, 13});
    tbl.push_back('{1, 0, 1, 8'h44, 1, 8'h04, 1, 2, 14});
    tbl.push_back('{1, 0, 1, 8'h44, 1, 8'h40, 1, 6, 15});
    tbl.push_back('{1, 0, 1, 8'h44, 0, 8'h00, 1, 6, 15});
    tbl.push_back('{1, 0, 1, 8'h44, 0, 8'h00, 1, 6, 15});
    tbl.push_back('{1, 0, 1, 8'h44, 0, 8'h00, 1, 6, 15});
    tbl.push_back('{1, 0, 1, 8'h44, 1, 8'h04, 1, 2, 16});
    tbl.push_back('{1, 0, 0, 8'hFF, 1, 8'h00, 0, 2, 16});
    tbl.push_back('{1, 0, 0, 8'hFF, 1, 8'h00, 0, 2, 16});
    tbl.push_back('{0, 9, 1, 8'hFF, 1, 8'h00, 0, 2, 16});
    tbl.push_back('{0, 7, 1, 8'h80, 1, 8'h80, 1, 7, 17});
    tbl.push_back('{1, 0, 1, 8'hFF, 1, 8'h08, 1, 3, 18});
    tbl.push_back('{0, 1, 1, 8'hFD, 1, 8'h00, 0, 3, 18});
    tbl.push_back('{0, 0, 1, 8'h01, 0, 8'h01, 1, 0, 19});
    tbl.push_back('{0, 0, 1, 8'h01, 0, 8'h00, 1, 0, 19});

    rst_n = 1'b0;
    set_data(64'h1000);
    in_valid = 8'hFF; mode = 1'b0; sel = 4'd5; en = 1'b1;
    out_ready = 1'b1;
    s_data = {8'hA2, 8'hA1, 8'hA0};
    s_valid = 3'b111; s_mode = 1'b0; s_sel = 2'd0;
    s_en = 1'b0; s_ordy = 1'b1;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_src", 64'(out_src), 64'h0);
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[n]) begin
      mode = tbl[n].mode; sel = tbl[n].sel; en = tbl[n].en;
      in_valid = tbl[n].iv; out_ready = tbl[n].ordy;
      #3;
      chk($sformatf("v%0d_in_ready", n), 64'(in_ready), 64'(tbl[n].rdy));
      tick();
      chk($sformatf("v%0d_out_valid", n), 64'(out_valid), 64'(tbl[n].ov));
      chk($sformatf("v%0d_out_src", n), 64'(out_src), 64'(tbl[n].src));
      chk($sformatf("v%0d_out_data", n), out_data,
          64'h1000 + 64'(tbl[n].src));
      chk($sformatf("v%0d_xfer_cnt", n), 64'(xfer_cnt), 64'(tbl[n].cnt));
    end

    // held beat must not follow changing inputs while stalled
    set_data(64'hDEAD_0000);
    in_valid = 8'hFF; mode = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk("stall_in_ready", 64'(in_ready), 64'h0);
      tick();
      chk("stall_out_data", out_data, 64'h1000);
      chk("stall_out_valid", 64'(out_valid), 64'h1);
    end

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_out_data", out_data, 64'h0);
    chk("arst_xfer_cnt", 64'(xfer_cnt), 64'h0);
    chk("arst_in_ready", 64'(in_ready), 64'h0);
    set_data(64'h1000);
    tick();
    rst_n = 1'b1; mode = 1'b1; en = 1'b1;
    in_valid = 8'hFF; out_ready = 1'b1;
    #3;
    chk("rr_restart_ready", 64'(in_ready), 64'h01);
    tick();
    chk("rr_restart_src0", 64'(out_src), 64'h0);
    chk("rr_restart_cnt1", 64'(xfer_cnt), 64'h1);
    tick();
    chk("rr_restart_src1", 64'(out_src), 64'h1);
    chk("rr_restart_data1", out_data, 64'h1001);
    en = 1'b0;
    tick();

    // 3-channel instance: wrap at NUM_IN-1 and counter saturation
    s_mode = 1'b1; s_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk($sformatf("sat%0d_src", c), 64'(s_src), 64'(c % 3));
      chk($sformatf("sat%0d_data", c), 64'(s_odata), 64'(8'hA0 + c % 3));
      chk($sformatf("sat%0d_cnt", c), 64'(s_cnt),
          64'((c + 1 > 7) ? 7 : c + 1));
    end
    s_mode = 1'b0; s_sel = 2'd3;
    #3;
    chk("sat_sel_oor_ready", 64'(s_ready), 64'h0);
    s_sel = 2'd2;
    #1;
    chk("sat_sel2_ready", 64'(s_ready), 64'h4);
    tick();
    chk("sat_sel2_src", 64'(s_src), 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
